// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle load/store unit between the core datapath and a handshaked data bus.
// Latches one access in IDLE, drives it onto the bus, formats the returned load
// data and holds the core with stall until the transaction completes.

module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  fmt_funct3;
  logic [1:0]  fmt_off;
  logic [31:0] rdata_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        launch;
  logic [3:0]  next_be;
  logic [31:0] next_wdata;
  logic [31:0] shifted_rdata;
  logic [31:0] formatted_rdata;

  // Decode access size and alignment from the live core inputs
  always_comb begin
    access     = mem_read | mem_write;
    is_byte    = (funct3 == 3'b000) || (funct3 == 3'b100);
    is_half    = (funct3 == 3'b001) || (funct3 == 3'b101);
    misaligned = 1'b0;
    if (access) begin
      if (is_half) begin
        misaligned = addr[0];
      end else if (!is_byte) begin
        misaligned = (addr[1:0] != 2'b00);
      end
    end
    launch = (state == ST_IDLE) && access && !misaligned;
  end

  // Byte-lane enables and lane-replicated store data for the access being launched
  always_comb begin
    next_be    = 4'b1111;
    next_wdata = store_data;
    if (is_byte) begin
      next_be    = 4'b0001 << addr[1:0];
      next_wdata = {4{store_data[7:0]}};
    end else if (is_half) begin
      next_be    = 4'b0011 << {addr[1], 1'b0};
      next_wdata = {2{store_data[15:0]}};
    end
  end

  // Align returned bus data to bit 0 and apply the latched sign/zero extension
  always_comb begin
    shifted_rdata = bus_rdata >> {fmt_off, 3'b000};
    case (fmt_funct3)
      3'b000:  formatted_rdata = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
      3'b001:  formatted_rdata = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b100:  formatted_rdata = {24'b0, shifted_rdata[7:0]};
      3'b101:  formatted_rdata = {16'b0, shifted_rdata[15:0]};
      default: formatted_rdata = shifted_rdata;
    endcase
  end

  // Core hold and load result; the IDLE term is masked while reset is asserted
  // so the core is released as soon as the FSM has been forced back to IDLE
  always_comb begin
    stall = ((state == ST_IDLE) && access && !misaligned && !reset) ||
            (state == ST_REQ) || (state == ST_WAIT);
    read_data = (state == ST_DONE) ? rdata_q : 32'd0;
  end

  // Transaction FSM with registered bus outputs and load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
      fmt_funct3 <= 3'd0;
      fmt_off    <= 2'd0;
      rdata_q    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state      <= ST_REQ;
            bus_req    <= 1'b1;
            bus_we     <= mem_write;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_be     <= next_be;
            bus_wdata  <= next_wdata;
            fmt_funct3 <= funct3;
            fmt_off    <= addr[1:0];
            rdata_q    <= 32'd0;
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= bus_we ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid) begin
            rdata_q <= formatted_rdata;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
